// File: rtl/vga_rect_fill_pkg.sv
// Shared VGA definitions: screen limits, colour width, draw-FSM encoding and the
// rectangle command payload carried through the command queue.
package vga_rect_fill_pkg;

    localparam int unsigned XMAX_DEFAULT = 160;
    localparam int unsigned YMAX_DEFAULT = 120;
    localparam int unsigned COORD_W      = 8;
    localparam int unsigned EXT_W        = COORD_W + 1;
    localparam int unsigned COLOUR_W     = 3;
    localparam int unsigned CMD_W        = 4 * COORD_W + COLOUR_W;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } draw_state_t;

    typedef struct packed {
        logic [COORD_W-1:0]  x;
        logic [COORD_W-1:0]  y;
        logic [COORD_W-1:0]  w;
        logic [COORD_W-1:0]  h;
        logic [COLOUR_W-1:0] colour;
    } rect_cmd_t;

    // Exclusive end coordinate of a span, clipped to the screen edge without wrapping.
    function automatic logic [EXT_W-1:0] clip_end(input logic [COORD_W-1:0] org,
                                                  input logic [COORD_W-1:0] len,
                                                  input logic [EXT_W-1:0]   lim);
        logic [EXT_W-1:0] sum;
        sum = EXT_W'(org) + EXT_W'(len);
        return (sum > lim) ? lim : sum;
    endfunction

endpackage

// File: rtl/vga_cmd_fifo.sv
// Synchronous show-ahead command queue; the head entry is visible on rd_data
// whenever empty is low, and pop retires it on the next edge.
module vga_cmd_fifo
    import vga_rect_fill_pkg::*;
#(
    parameter int unsigned WIDTH = CMD_W,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage needs no reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_rect_fill.sv
// Queued rectangle filler: plots one pixel per cycle in raster order to a VGA
// adapter, clipping at the screen edge and chaining queued commands with no gap.
module vga_rect_fill
    import vga_rect_fill_pkg::*;
#(
    parameter int unsigned XMAX       = XMAX_DEFAULT,
    parameter int unsigned YMAX       = YMAX_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [COORD_W-1:0]  cmd_x,
    input  logic [COORD_W-1:0]  cmd_y,
    input  logic [COORD_W-1:0]  cmd_w,
    input  logic [COORD_W-1:0]  cmd_h,
    input  logic [COLOUR_W-1:0] cmd_colour,
    output logic [COORD_W-1:0]  vgax,
    output logic [COORD_W-1:0]  vgay,
    output logic [COLOUR_W-1:0] colour,
    output logic                vgaw,
    output logic                busy
);

    draw_state_t         state_q, state_d;
    logic [COORD_W-1:0]  cur_x_q, cur_x_d;
    logic [COORD_W-1:0]  cur_y_q, cur_y_d;
    logic [COORD_W-1:0]  x_org_q, x_org_d;
    logic [EXT_W-1:0]    x_end_q, x_end_d;
    logic [EXT_W-1:0]    y_end_q, y_end_d;
    logic [COLOUR_W-1:0] fill_q, fill_d;
    logic [COORD_W-1:0]  vgax_d, vgay_d;
    logic [COLOUR_W-1:0] colour_d;
    logic                vgaw_d;

    rect_cmd_t           wr_cmd, head;
    logic                fifo_full, fifo_empty;
    logic                push, pop, load_head;
    logic [EXT_W-1:0]    head_x_end, head_y_end;
    logic                head_drawable;
    logic                x_last, y_last;

    assign wr_cmd    = {cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour};
    assign cmd_ready = reset | ~fifo_full;
    assign push      = cmd_valid & cmd_ready;
    assign busy      = ~reset & ((state_q == DRAW) | ~fifo_empty);

    vga_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (wr_cmd),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Head-of-queue decode: clipped extents and whether anything is on-screen.
    assign head_x_end    = clip_end(head.x, head.w, EXT_W'(XMAX));
    assign head_y_end    = clip_end(head.y, head.h, EXT_W'(YMAX));
    assign head_drawable = (EXT_W'(head.x) < EXT_W'(XMAX)) && (EXT_W'(head.y) < EXT_W'(YMAX))
                           && (head.w != '0) && (head.h != '0);

    assign x_last = (EXT_W'(cur_x_q) == x_end_q - EXT_W'(1));
    assign y_last = (EXT_W'(cur_y_q) == y_end_q - EXT_W'(1));

    always_comb begin
        state_d   = state_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        x_org_d   = x_org_q;
        x_end_d   = x_end_q;
        y_end_d   = y_end_q;
        fill_d    = fill_q;
        vgax_d    = vgax;
        vgay_d    = vgay;
        colour_d  = colour;
        vgaw_d    = 1'b0;
        load_head = 1'b0;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load_head = 1'b1;
                end
            end
            DRAW: begin
                vgaw_d   = 1'b1;
                vgax_d   = cur_x_q;
                vgay_d   = cur_y_q;
                colour_d = fill_q;
                if (!x_last) begin
                    cur_x_d = cur_x_q + COORD_W'(1);
                end else if (!y_last) begin
                    cur_x_d = x_org_q;
                    cur_y_d = cur_y_q + COORD_W'(1);
                end else if (!fifo_empty) begin
                    load_head = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Loading retires the entry even when it is discarded as off-screen or empty.
        if (load_head) begin
            pop     = 1'b1;
            state_d = head_drawable ? DRAW : IDLE;
            cur_x_d = head.x;
            cur_y_d = head.y;
            x_org_d = head.x;
            x_end_d = head_x_end;
            y_end_d = head_y_end;
            fill_d  = head.colour;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cur_x_q <= '0;
            cur_y_q <= '0;
            x_org_q <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
            fill_q  <= '0;
            vgax    <= '0;
            vgay    <= '0;
            colour  <= '0;
            vgaw    <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            x_org_q <= x_org_d;
            x_end_q <= x_end_d;
            y_end_q <= y_end_d;
            fill_q  <= fill_d;
            vgax    <= vgax_d;
            vgay    <= vgay_d;
            colour  <= colour_d;
            vgaw    <= vgaw_d;
        end
    end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Bench for vga_rect_fill: each command is expanded into its expected clipped
// pixel list, and observed plot strobes are compared against it in order.
module tb_vga_rect_fill;

    localparam int XMAX = 160;
    localparam int YMAX = 120;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
    logic [2:0] cmd_colour = '0;
    logic [7:0] vgax, vgay;
    logic [2:0] colour;
    logic       vgaw;
    logic       busy;

    vga_rect_fill #(.XMAX(XMAX), .YMAX(YMAX), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_colour (cmd_colour),
        .vgax       (vgax),
        .vgay       (vgay),
        .colour     (colour),
        .vgaw       (vgaw),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
        int cyc;
    } pix_t;

    pix_t obs_q[$];
    pix_t exp_q[$];
    int   cyc = 0;
    int   ready_low_cnt = 0;
    int   last_accept = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Plot monitor, sampled mid-cycle.
    always @(negedge clk) begin
        pix_t p;
        if (!reset && vgaw) begin
            p.x = int'(vgax);
            p.y = int'(vgay);
            p.c = int'(colour);
            p.cyc = cyc;
            obs_q.push_back(p);
        end
        if (!reset && !cmd_ready) ready_low_cnt++;
    end

    // Reference: every on-screen pixel of the rectangle, row by row.
    task automatic model_rect(input int x, input int y, input int w, input int h, input int c);
        pix_t p;
        if (x >= XMAX || y >= YMAX) return;
        for (int yy = y; yy < y + h && yy < YMAX; yy++) begin
            for (int xx = x; xx < x + w && xx < XMAX; xx++) begin
                p.x = xx;
                p.y = yy;
                p.c = c;
                p.cyc = 0;
                exp_q.push_back(p);
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int x, input int y, input int w, input int h, input int c);
        int t = 0;
        cmd_valid  = 1'b1;
        cmd_x      = 8'(x);
        cmd_y      = 8'(y);
        cmd_w      = 8'(w);
        cmd_h      = 8'(h);
        cmd_colour = 3'(c);
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_accept: cmd_ready stayed %b, required 1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid   = 1'b0;
        last_accept = cyc;
        model_rect(x, y, w, h, c);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (busy && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_idle: busy=%b after %0d cycles, required 0", busy, budget);
        end
    endtask

    task automatic clear_queues();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({vgaw, vgax, vgay, colour, busy, cmd_ready} !== {1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_during: vgaw=%b x=%0d y=%0d c=%0d busy=%b ready=%b, required 0 0 0 0 0 1",
                     vgaw, vgax, vgay, colour, busy, cmd_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({vgaw, vgax, vgay, colour, busy, cmd_ready} !== {1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_after: vgaw=%b x=%0d y=%0d c=%0d busy=%b ready=%b, required 0 0 0 0 0 1",
                     vgaw, vgax, vgay, colour, busy, cmd_ready);
        end
        clear_queues();
    endtask

    task automatic test_basic();
        clear_queues();
        send(10, 5, 2, 2, 3);
        wait_idle(100);
        n_cmp++;
        if (obs_q.size() != 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d plots, required 4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y || obs_q[i].c != exp_q[i].c) begin
                n_fail++;
                $display("FAIL basic_pixel[%0d]: got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)", i,
                         obs_q[i].x, obs_q[i].y, obs_q[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
            end
        end
        if (obs_q.size() == 4) begin
            n_cmp++;
            if (obs_q[0].cyc != last_accept + 2) begin
                n_fail++;
                $display("FAIL basic_latency: first plot cycle %0d, required %0d", obs_q[0].cyc, last_accept + 2);
            end
            n_cmp++;
            if (obs_q[3].cyc != obs_q[0].cyc + 3) begin
                n_fail++;
                $display("FAIL basic_contiguous: last plot cycle %0d, required %0d", obs_q[3].cyc, obs_q[0].cyc + 3);
            end
        end
    endtask

    task automatic test_corner();
        clear_queues();
        send(158, 118, 4, 4, 5);
        wait_idle(100);
        n_cmp++;
        if (obs_q.size() != 4) begin
            n_fail++;
            $display("FAIL corner_count: got %0d plots, required 4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y || obs_q[i].c != exp_q[i].c) begin
                n_fail++;
                $display("FAIL corner_pixel[%0d]: got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)", i,
                         obs_q[i].x, obs_q[i].y, obs_q[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
            end
        end
    endtask

    task automatic test_discard();
        clear_queues();
        send(20, 20, 0, 5, 1);
        send(200, 10, 3, 3, 2);
        wait_idle(100);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL discard_count: got %0d plots, required 0", obs_q.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        ready_low_cnt = 0;
        send(40, 50, 3, 1, 1);
        send(60, 51, 3, 1, 2);
        send(80, 52, 3, 1, 4);
        wait_idle(100);
        n_cmp++;
        if (obs_q.size() != 9) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d plots, required 9", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y || obs_q[i].c != exp_q[i].c
                || obs_q[i].cyc != obs_q[0].cyc + i) begin
                n_fail++;
                $display("FAIL b2b_pixel[%0d]: got (%0d,%0d,c%0d)@%0d required (%0d,%0d,c%0d)@%0d", i,
                         obs_q[i].x, obs_q[i].y, obs_q[i].c, obs_q[i].cyc,
                         exp_q[i].x, exp_q[i].y, exp_q[i].c, obs_q[0].cyc + i);
            end
        end
        n_cmp++;
        if (ready_low_cnt == 0) begin
            n_fail++;
            $display("FAIL b2b_ready_low: cmd_ready low for %0d cycles, required at least 1", ready_low_cnt);
        end
    endtask

    task automatic test_random();
        int x, y, w, h, c;
        clear_queues();
        for (int n = 0; n < 25; n++) begin
            x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 165)) : int'($urandom_range(0, 150));
            y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(112, 125)) : int'($urandom_range(0, 112));
            w = int'($urandom_range(0, 6));
            h = int'($urandom_range(0, 4));
            c = int'($urandom_range(0, 7));
            send(x, y, w, h, c);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(3000);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d plots, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y || obs_q[i].c != exp_q[i].c) begin
                n_fail++;
                $display("FAIL random_pixel[%0d]: got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)", i,
                         obs_q[i].x, obs_q[i].y, obs_q[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
            end
        end
    endtask

    task automatic test_reset_mid_draw();
        int t = 0;
        int seen;
        clear_queues();
        send(30, 40, 10, 10, 6);
        while (obs_q.size() < 15 && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (obs_q.size() < 15) begin
            n_fail++;
            $display("FAIL midreset_progress: got %0d plots, required at least 15", obs_q.size());
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({vgaw, busy, cmd_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL midreset_during: vgaw=%b busy=%b ready=%b, required 0 0 1", vgaw, busy, cmd_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({vgaw, busy, cmd_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL midreset_after: vgaw=%b busy=%b ready=%b, required 0 0 1", vgaw, busy, cmd_ready);
        end
        seen = obs_q.size();
        for (int i = 0; i < seen && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y || obs_q[i].c != exp_q[i].c) begin
                n_fail++;
                $display("FAIL midreset_pixel[%0d]: got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)", i,
                         obs_q[i].x, obs_q[i].y, obs_q[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
            end
        end
        repeat (150) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != seen || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_resume: plots %0d busy=%b, required %0d and 0", obs_q.size(), busy, seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corner();
        test_discard();
        test_back_to_back();
        test_random();
        test_reset_mid_draw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_rect_fill.md
VGA_RECT_FILL -- requirements
Module: vga_rect_fill

Interface
REQ-001 Parameter XMAX, default 160: screen width in pixels; x at or beyond XMAX is off-screen.
REQ-002 Parameter YMAX, default 120: screen height in pixels; y at or beyond YMAX is off-screen.
REQ-003 Parameter FIFO_DEPTH, default 2: command queue depth in entries.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 cmd_valid  input  1: rectangle command present.
REQ-007 cmd_ready  output  1: queue can accept a command this cycle.
REQ-008 cmd_x, cmd_y  input  8 each: top-left corner.
REQ-009 cmd_w, cmd_h  input  8 each: width and height in pixels.
REQ-010 cmd_colour  input  3: fill colour.
REQ-011 vgax, vgay  output  8 each: pixel coordinate to the VGA adapter.
REQ-012 colour  output  3: pixel colour to the VGA adapter.
REQ-013 vgaw  output  1: plot strobe to the VGA adapter (adapter plot input).
REQ-014 busy  output  1: queue non-empty or draw in progress.

Function
REQ-015 A command SHALL be accepted on each edge where cmd_valid and cmd_ready are both high; cmd_ready SHALL be high exactly when the queue is not full.
REQ-016 FSM states SHALL be IDLE and DRAW.
REQ-017 In IDLE with the queue non-empty, the FSM SHALL pop one entry, load it, and compute x_end = min(x+w, XMAX) and y_end = min(y+h, YMAX) using 9-bit arithmetic (no wrap).
REQ-018 If x >= XMAX, y >= YMAX, w == 0 or h == 0, the entry SHALL be discarded with no plot and the FSM SHALL stay IDLE.
REQ-019 Otherwise the FSM SHALL enter DRAW with cur_x = x, cur_y = y.
REQ-020 vgaw, vgax, vgay and colour SHALL be registered; vgaw SHALL be 1 exactly in DRAW cycles, one pixel per cycle.
REQ-021 Pixel order SHALL be raster: cur_x increments to x_end-1, then resets to x and cur_y increments, ending at (x_end-1, y_end-1).
REQ-022 Latency: the first vgaw=1 cycle SHALL begin at the second edge after the accepting edge when the FSM is IDLE and the queue is empty.
REQ-023 On the last pixel with the queue non-empty, the FSM SHALL pop and load the next entry on the same edge, giving zero gap cycles; a discarded next entry returns the FSM to IDLE.
REQ-024 Push and pop on the same edge SHALL both take effect; an empty queue SHALL never be popped on the same edge it is written.
REQ-025 busy SHALL equal (state == DRAW) or (queue non-empty).

Reset
REQ-026 On reset the FSM SHALL enter IDLE and the queue SHALL empty, regardless of any draw in progress.
REQ-027 During reset and on the cycle after it, vgaw, vgax, vgay, colour and busy SHALL be 0 and cmd_ready SHALL be 1.

Structure
REQ-028 XMAX/YMAX defaults, colour width and state encodings SHALL live in the shared VGA package or header used with the VGA adapter.
REQ-029 The command queue SHALL be a sub-module, vga_cmd_fifo: synchronous, width 35 bits, depth FIFO_DEPTH, with full and empty flags.

Verification
REQ-030 Cmd (10,5,w2,h2,colour 3) into idle block -> vgaw high 4 consecutive cycles at (10,5), (11,5), (10,6), (11,6), colour 3, first plot per REQ-022.
REQ-031 Cmd (158,118,4,4) -> exactly 4 plots: (158,118), (159,118), (158,119), (159,119).
REQ-032 Cmd (20,20,0,5), then cmd (200,10,3,3) -> no vgaw pulses; busy returns to 0.
REQ-033 Three back-to-back cmds of size 3x1 -> cmd_ready low while the queue is full; 9 contiguous plot cycles with no gap.
REQ-034 Reset asserted mid-draw of a 10x10 cmd -> vgaw 0 next cycle, busy 0, cmd_ready 1; the remaining pixels are never plotted.
